// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the instruction decoder and the multiply/divide
// engine: launch controls, operands, HI/LO read request and the results.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_rd;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, op_signed, a, b, hilo_rd,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op_div, op_signed, a, b, hilo_rd,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine owning the HI/LO pair.
// Radix-2 shift-add multiply or restoring divide, one bit per clock.
// Optional feature macro: MULDIV_SIGNED_EN adds signed operation via operand
// magnitudes plus a one-cycle sign-fix state (FIX).
//
// state  | meaning
// IDLE   | waiting for start; HI/LO hold the last result
// MUL    | shift-add iterations, cnt counts 0..WIDTH-1
// DIV    | restoring-divide iterations, cnt counts 0..WIDTH-1
// FIX    | (signed build only) apply result signs, then write HI/LO
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef MULDIV_SIGNED_EN
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
`else
    S_DIV  = 2'd2
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  // r_x: accumulator (mul) / remainder (div)
  // r_y: multiplier shifting out, product low (mul) / dividend shifting into quotient (div)
  // r_z: multiplicand (mul) / divisor (div)
  logic [WIDTH-1:0] r_x, r_y, r_z;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;

  logic             w_accept, w_finish, w_last;
  logic [WIDTH:0]   w_add, w_rem_sh, w_trial;
  logic [WIDTH-1:0] w_step_x, w_step_y;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic [WIDTH-1:0] w_ld_y, w_ld_z;

`ifdef MULDIV_SIGNED_EN
  logic             r_sgn, r_a_neg, r_b_neg, r_op_div;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_prod;

  // Signed launch works on magnitudes; signs are reapplied in FIX.
  always_comb begin
    w_a_neg = bus.op_signed & bus.a[WIDTH-1];
    w_b_neg = bus.op_signed & bus.b[WIDTH-1];
    w_a_mag = w_a_neg ? (WIDTH'(0) - bus.a) : bus.a;
    w_b_mag = w_b_neg ? (WIDTH'(0) - bus.b) : bus.b;
    w_prod  = {r_x, r_y};
  end
`endif

  // Operand routing at launch and one iteration of either datapath.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    w_ld_y = bus.op_div ? w_a_mag : w_b_mag;
    w_ld_z = bus.op_div ? w_b_mag : w_a_mag;
`else
    w_ld_y = bus.op_div ? bus.a : bus.b;
    w_ld_z = bus.op_div ? bus.b : bus.a;
`endif
    w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    w_add    = {1'b0, r_x} + (r_y[0] ? {1'b0, r_z} : {(WIDTH+1){1'b0}});
    // remainder stays below the divisor, so WIDTH+1 bits carry the sign
    w_rem_sh = {r_x, r_y[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_z};
    if (r_state == S_DIV) begin
      w_step_x = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
      w_step_y = {r_y[WIDTH-2:0], ~w_trial[WIDTH]};
    end else begin
      w_step_x = w_add[WIDTH:1];
      w_step_y = {w_add[0], r_y[WIDTH-1:1]};
    end
    w_res_hi = w_step_x;
    w_res_lo = w_step_y;
`ifdef MULDIV_SIGNED_EN
    if (r_state == S_FIX) begin
      if (r_op_div) begin
        w_res_lo = (r_a_neg ^ r_b_neg) ? (WIDTH'(0) - r_y) : r_y;
        w_res_hi = r_a_neg ? (WIDTH'(0) - r_x) : r_x;
      end else if (r_a_neg ^ r_b_neg) begin
        {w_res_hi, w_res_lo} = (2*WIDTH)'(0) - w_prod;
      end else begin
        {w_res_hi, w_res_lo} = w_prod;
      end
    end
`endif
  end

  // Next-state and sequencing strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = bus.op_div ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) begin
`ifdef MULDIV_SIGNED_EN
          if (r_sgn) begin
            w_state_nxt = S_FIX;
          end else begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end
`else
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_FIX: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath, iteration counter and HI/LO result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_cnt <= '0;
        r_x   <= '0;
        r_y   <= w_ld_y;
        r_z   <= w_ld_z;
      end else if (r_state == S_MUL || r_state == S_DIV) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_x   <= w_step_x;
        r_y   <= w_step_y;
      end
      if (w_finish) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Sign bookkeeping captured at launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sgn    <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_op_div <= 1'b0;
    end else if (w_accept) begin
      r_sgn    <= bus.op_signed;
      r_a_neg  <= w_a_neg;
      r_b_neg  <= w_b_neg;
      r_op_div <= bus.op_div;
    end
  end
`endif

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.stall = bus.hilo_rd & (bus.busy | bus.start);

endmodule
